// File: rtl/pes_traffic_pkg.sv
// Shared lamp, phase, fault and FSM encodings
// for the traffic light read-back monitor.
package pes_traffic_pkg;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [1:0] {
    HGRE_FRED = 2'b00,
    HYEL_FRED = 2'b01,
    HRED_FGRE = 2'b10,
    HRED_FYEL = 2'b11
  } phase_t;

  typedef enum logic [2:0] {
    F_NONE      = 3'd0,
    F_BAD_ENC   = 3'd1,
    F_CONFLICT  = 3'd2,
    F_SEQ       = 3'd3,
    F_SHORT_YEL = 3'd4,
    F_STUCK     = 3'd5
  } fault_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/pes_traffic_monitor_decode.sv
// One lamp bus to one-hot lamp flags;
// valid is low for any non one-hot pattern.
module pes_lamp_decode
  import pes_traffic_pkg::*;
(
  input  logic [2:0] lamp,
  output logic       is_r,
  output logic       is_y,
  output logic       is_g,
  output logic       valid
);

  assign is_r  = (lamp == LAMP_R);
  assign is_y  = (lamp == LAMP_Y);
  assign is_g  = (lamp == LAMP_G);
  assign valid = is_r | is_y | is_g;

endmodule

// File: rtl/pes_traffic_monitor.sv
// Sequence/conflict monitor on the lamp outputs;
// latches the first violation until fault_clr.
module pes_traffic_monitor
  import pes_traffic_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int YEL_MIN   = 2,
  parameter int MAX_PHASE = 20,
  parameter int DW        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light_highway,
  input  logic [2:0] light_farm,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] phase,
  output logic       phase_valid
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [2:0]    s_hw, s_fm;
  logic          h_r, h_y, h_g, h_v;
  logic          f_r, f_y, f_g, f_v;
  logic [PW-1:0] presc;
  logic          tick;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d, d_phase;
  fault_t        code_q, code_d, viol;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          bad_enc, conflict, both_red;
  logic          changed, legal_step;
  logic [1:0]    nxt;

  // Reset to R/R so INIT waits for a real phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_hw <= LAMP_R;
      s_fm <= LAMP_R;
    end else begin
      s_hw <= light_highway;
      s_fm <= light_farm;
    end
  end

  pes_lamp_decode u_dec_hw (
    .lamp  (s_hw),
    .is_r  (h_r),
    .is_y  (h_y),
    .is_g  (h_g),
    .valid (h_v)
  );

  pes_lamp_decode u_dec_fm (
    .lamp  (s_fm),
    .is_r  (f_r),
    .is_y  (f_y),
    .is_g  (f_g),
    .valid (f_v)
  );

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  always_comb begin
    d_phase  = HGRE_FRED;
    bad_enc  = !(h_v && f_v);
    conflict = 1'b0;
    both_red = 1'b0;
    if (!bad_enc) begin
      unique case (1'b1)
        h_g && f_r: d_phase  = HGRE_FRED;
        h_y && f_r: d_phase  = HYEL_FRED;
        h_r && f_g: d_phase  = HRED_FGRE;
        h_r && f_y: d_phase  = HRED_FYEL;
        h_r && f_r: both_red = 1'b1;
        default:    conflict = 1'b1;
      endcase
    end
  end

  assign nxt        = phase_q + 2'd1;
  assign changed    = (d_phase != phase_q);
  assign legal_step = (d_phase == phase_t'(nxt));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    code_d  = code_q;
    viol    = F_NONE;
    unique case (state_q)
      INIT: begin
        dwell_d = '0;
        if (bad_enc)       viol = F_BAD_ENC;
        else if (conflict) viol = F_CONFLICT;
        else if (!both_red) begin
          phase_d = d_phase;
          state_d = RUN;
        end
      end
      RUN: begin
        // Ordered so the lowest fault code wins
        if (bad_enc)                 viol = F_BAD_ENC;
        else if (conflict)           viol = F_CONFLICT;
        else if (both_red)           viol = F_SEQ;
        else if (changed && !legal_step)
          viol = F_SEQ;
        else if (changed && phase_q[0] &&
                 dwell_q < DW'(YEL_MIN))
          viol = F_SHORT_YEL;
        else if (phase_q != HGRE_FRED &&
                 dwell_q > DW'(MAX_PHASE))
          viol = F_STUCK;
        if (viol == F_NONE) begin
          if (changed) begin
            phase_d = d_phase;
            dwell_d = '0;
          end else if (tick && dwell_q != '1) begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      FAULT: begin
        dwell_d = '0;
        if (fault_clr) begin
          state_d = INIT;
          code_d  = F_NONE;
        end
      end
      default: begin
        state_d = INIT;
        code_d  = F_NONE;
        dwell_d = '0;
      end
    endcase
    if (viol != F_NONE) begin
      state_d = FAULT;
      code_d  = viol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      phase_q <= HGRE_FRED;
      dwell_q <= '0;
      code_q  <= F_NONE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      code_q  <= code_d;
    end
  end

  assign fault       = (state_q == FAULT);
  assign fault_code  = code_q;
  assign phase       = phase_q;
  assign phase_valid = (state_q == RUN);

endmodule

// File: tb/tb_pes_traffic_monitor.sv
// Scoreboard bench: a behavioural model predicts
// every cycle's outputs; a monitor compares them.
module tb_pes_traffic_monitor;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] light_highway = LR;
  logic [2:0] light_farm = LR;
  logic       fault_clr = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] phase;
  logic       phase_valid;

  pes_traffic_monitor #(
    .TICK_DIV  (4),
    .YEL_MIN   (2),
    .MAX_PHASE (20),
    .DW        (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .light_highway (light_highway),
    .light_farm    (light_farm),
    .fault_clr     (fault_clr),
    .fault         (fault),
    .fault_code    (fault_code),
    .phase         (phase),
    .phase_valid   (phase_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       f;
    logic [2:0] c;
    logic [1:0] p;
    logic       pv;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model: st 0=init 1=run 2=fault
  int         m_st, m_code, m_ph, m_dw, m_pre;
  logic [2:0] m_sh, m_sf;

  logic [2:0] ph_h[4] = '{LG, LY, LR, LR};
  logic [2:0] ph_f[4] = '{LR, LR, LG, LY};

  // 0..3 phase, 4 red/red, 5 conflict, 6 bad encoding
  function automatic int classify(logic [2:0] h, logic [2:0] f);
    bit hr, hy, hg, fr, fy, fg;
    hr = (h == LR); hy = (h == LY); hg = (h == LG);
    fr = (f == LR); fy = (f == LY); fg = (f == LG);
    if (!(hr | hy | hg) || !(fr | fy | fg)) return 6;
    if (hg && fr) return 0;
    if (hy && fr) return 1;
    if (hr && fg) return 2;
    if (hr && fy) return 3;
    if (hr && fr) return 4;
    return 5;
  endfunction

  task automatic model_reset();
    m_st = 0; m_code = 0; m_ph = 0; m_dw = 0; m_pre = 0;
    m_sh = LR; m_sf = LR;
  endtask

  task automatic model_step(input logic [2:0] h,
                            input logic [2:0] f,
                            input bit c);
    int  k, v;
    bit  tick;
    tick  = (m_pre == 3);
    m_pre = (m_pre + 1) % 4;
    k     = classify(m_sh, m_sf);
    v     = 0;
    if (m_st == 0) begin
      if (k == 6)      v = 1;
      else if (k == 5) v = 2;
      else if (k < 4) begin
        m_ph = k; m_dw = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (k == 6)      v = 1;
      else if (k == 5) v = 2;
      else if (k == 4) v = 3;
      else if (k != m_ph && k != (m_ph + 1) % 4) v = 3;
      else if (k != m_ph && (m_ph % 2) == 1 && m_dw < 2) v = 4;
      else if (m_ph != 0 && m_dw > 20) v = 5;
      if (v == 0) begin
        if (k != m_ph) begin
          m_ph = k; m_dw = 0;
        end else if (tick && m_dw < 255) begin
          m_dw++;
        end
      end
    end else if (c) begin
      m_st = 0; m_code = 0;
    end
    if (v != 0) begin
      m_st = 2; m_code = v; m_dw = 0;
    end
    m_sh = h; m_sf = f;
  endtask

  task automatic cyc(input logic [2:0] h, input logic [2:0] f,
                     input bit c, input bit r);
    exp_t e;
    @(negedge clk);
    light_highway = h;
    light_farm    = f;
    fault_clr     = c;
    rst_n         = r;
    if (!r) model_reset();
    else    model_step(h, f, c);
    e.f  = (m_st == 2);
    e.c  = 3'(m_code);
    e.p  = 2'(m_ph);
    e.pv = (m_st == 1);
    q.push_back(e);
  endtask

  task automatic hold(input logic [2:0] h, input logic [2:0] f,
                      input int n);
    for (int i = 0; i < n; i++) cyc(h, f, 1'b0, 1'b1);
  endtask

  task automatic clr_pulse(input logic [2:0] h, input logic [2:0] f);
    cyc(h, f, 1'b1, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if (fault !== e.f || fault_code !== e.c ||
            phase !== e.p || phase_valid !== e.pv) begin
          n_bad++;
          $display("FAIL outputs t=%0t got f=%b c=%0d p=%0d pv=%b want f=%b c=%0d p=%0d pv=%b",
                   $time, fault, fault_code, phase, phase_valid,
                   e.f, e.c, e.p, e.pv);
        end
      end
    end
  end

  initial begin : stim
    int p, r, n;
    model_reset();
    repeat (3) cyc(LR, LR, 1'b0, 1'b0);

    // normal cycle, long HG/FR never stuck
    hold(LG, LR, 160);
    hold(LY, LR, 12);
    hold(LR, LG, 40);
    hold(LR, LY, 12);
    hold(LG, LR, 20);

    // conflict for one cycle stays latched
    hold(LG, LG, 1);
    hold(LG, LR, 10);
    clr_pulse(LG, LR);
    hold(LG, LR, 8);

    // bad encoding beats conflict
    hold(3'b011, LG, 1);
    hold(LG, LR, 5);
    clr_pulse(LG, LR);
    hold(LG, LR, 8);

    // skipped yellow
    hold(LR, LG, 4);
    clr_pulse(LG, LR);
    hold(LG, LR, 8);

    // short yellow
    hold(LY, LR, 4);
    hold(LR, LG, 4);
    clr_pulse(LG, LR);
    hold(LG, LR, 8);

    // stuck in HR/FG
    hold(LY, LR, 12);
    hold(LR, LG, 88);
    clr_pulse(LG, LR);
    hold(LG, LR, 8);

    // reset mid-run
    hold(LY, LR, 6);
    cyc(LY, LR, 1'b0, 1'b0);
    hold(LY, LR, 4);
    hold(LR, LG, 4);

    // randomized walk with faults, clears, resets
    p = 2;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        hold(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             $urandom_range(1, 3));
      end else if (r == 1) begin
        clr_pulse(ph_h[p], ph_f[p]);
      end else if (r == 2) begin
        cyc(ph_h[p], ph_f[p], 1'b0, 1'b0);
      end else begin
        if (r == 3) p = $urandom_range(0, 3);
        else        p = (p + 1) % 4;
        n = (p % 2 == 1) ? $urandom_range(3, 14) : $urandom_range(4, 100);
        hold(ph_h[p], ph_f[p], n);
      end
    end

    hold(LG, LR, 3);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
